// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 core: state array, round
// constants and the control FSM state encoding.
package ascon_pack;

  typedef logic [63:0] type_state [0:4];

  localparam logic [7:0] ROUND_CONSTANT [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Round-counter values the FSM decodes; p^b rounds start at 6.
  localparam logic [3:0] CNT_LAST       = 4'd11;
  localparam logic [3:0] CNT_PT_CYPHER  = 4'd7;
  localparam logic [3:0] CNT_FIN_CYPHER = 4'd1;

  typedef enum logic [3:0] {
    IDLE,
    INIT_CONF,
    INIT_START,
    INIT_RUN,
    WAIT_AD,
    AD_START,
    AD_RUN,
    WAIT_PT,
    PT_START,
    PT_RUN,
    FIN_CONF,
    FIN_START,
    FIN_RUN,
    DONE
  } fsm_state_t;

endpackage

// File: rtl/ascon_state_machine.sv
// Control FSM of the ASCON-128 encryption core: sequences init, one AD block,
// plaintext blocks and finalisation by strobing the datapath and counters.
module ascon_state_machine
  import ascon_pack::*;
#(
  parameter logic [3:0] LAST_BLOCK = 4'd5
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic [3:0] counter_block_i,
  input  logic [3:0] counter_clock_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       end_o,
  output logic       cypher_valid_o,
  output logic       data_sel_o,
  output logic       en_reg_state_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_xor_data_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       enable_clock_counter_o,
  output logic       enable_block_counter_o
);

  fsm_state_t state, next_state;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    // NOTE: every output and next_state gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    next_state             = state;
    end_o                  = 1'b0;
    cypher_valid_o         = 1'b0;
    data_sel_o             = 1'b0;
    en_reg_state_o         = 1'b0;
    en_xor_key_o           = 1'b0;
    en_xor_key_end_o       = 1'b0;
    en_xor_lsb_o           = 1'b0;
    en_xor_data_o          = 1'b0;
    en_cipher_o            = 1'b0;
    en_tag_o               = 1'b0;
    init_a_o               = 1'b0;
    init_b_o               = 1'b0;
    enable_clock_counter_o = 1'b0;
    enable_block_counter_o = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) next_state = INIT_CONF;
      end

      INIT_CONF: begin
        init_a_o               = 1'b1;
        enable_clock_counter_o = 1'b1;
        next_state             = INIT_START;
      end

      // First round takes the fresh init state from state_i, not the register.
      INIT_START: begin
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        next_state             = INIT_RUN;
      end

      INIT_RUN: begin
        data_sel_o             = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        if (counter_clock_i == CNT_LAST) begin
          en_xor_key_end_o       = 1'b1;
          init_b_o               = 1'b1;
          enable_block_counter_o = 1'b1;
          next_state             = WAIT_AD;
        end
      end

      WAIT_AD: begin
        if (data_valid_i) next_state = AD_START;
      end

      AD_START: begin
        data_sel_o             = 1'b1;
        en_xor_data_o          = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        next_state             = AD_RUN;
      end

      // Domain separation bit is applied after the last AD round.
      AD_RUN: begin
        data_sel_o             = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        if (counter_clock_i == CNT_LAST) begin
          en_xor_lsb_o           = 1'b1;
          init_b_o               = 1'b1;
          enable_block_counter_o = 1'b1;
          next_state             = WAIT_PT;
        end
      end

      WAIT_PT: begin
        if (data_valid_i) begin
          if (counter_block_i == LAST_BLOCK) next_state = FIN_CONF;
          else                               next_state = PT_START;
        end
      end

      PT_START: begin
        data_sel_o             = 1'b1;
        en_xor_data_o          = 1'b1;
        en_cipher_o            = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        next_state             = PT_RUN;
      end

      PT_RUN: begin
        data_sel_o             = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        if (counter_clock_i == CNT_PT_CYPHER) cypher_valid_o = 1'b1;
        if (counter_clock_i == CNT_LAST) begin
          init_b_o               = 1'b1;
          enable_block_counter_o = 1'b1;
          next_state             = WAIT_PT;
        end
      end

      FIN_CONF: begin
        init_a_o   = 1'b1;
        next_state = FIN_START;
      end

      FIN_START: begin
        data_sel_o             = 1'b1;
        en_xor_data_o          = 1'b1;
        en_cipher_o            = 1'b1;
        en_xor_key_o           = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        next_state             = FIN_RUN;
      end

      FIN_RUN: begin
        data_sel_o             = 1'b1;
        en_reg_state_o         = 1'b1;
        enable_clock_counter_o = 1'b1;
        if (counter_clock_i == CNT_FIN_CYPHER) cypher_valid_o = 1'b1;
        if (counter_clock_i == CNT_LAST) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          next_state       = DONE;
        end
      end

      DONE: begin
        end_o = 1'b1;
        if (!start_i) next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_state_machine.sv
// Directed bench for the ASCON control FSM: models the sibling round and block
// counters and checks per-cycle strobe vectors against a queue of expectations.
module tb_ascon_state_machine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       data_valid = 1'b0;
  logic [3:0] cnt_clk;
  logic [3:0] cnt_blk;

  logic end_s, cv, dsel, ereg, xkey, xkend, xlsb, xdata, ciph, tag, ia, ib, clk_en, blk_en;

  ascon_state_machine dut (
    .clock_i                (clk),
    .resetb_i               (rst_n),
    .counter_block_i        (cnt_blk),
    .counter_clock_i        (cnt_clk),
    .start_i                (start),
    .data_valid_i           (data_valid),
    .end_o                  (end_s),
    .cypher_valid_o         (cv),
    .data_sel_o             (dsel),
    .en_reg_state_o         (ereg),
    .en_xor_key_o           (xkey),
    .en_xor_key_end_o       (xkend),
    .en_xor_lsb_o           (xlsb),
    .en_xor_data_o          (xdata),
    .en_cipher_o            (ciph),
    .en_tag_o               (tag),
    .init_a_o               (ia),
    .init_b_o               (ib),
    .enable_clock_counter_o (clk_en),
    .enable_block_counter_o (blk_en)
  );

  always #5 clk = ~clk;

  // Sibling counters: init has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_clk <= 4'd0;
    else if (ia)     cnt_clk <= 4'd0;
    else if (ib)     cnt_clk <= 4'd6;
    else if (clk_en) cnt_clk <= cnt_clk + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_blk <= 4'd0;
    else if (blk_en) cnt_blk <= cnt_blk + 4'd1;
  end

  localparam logic [13:0] M_END   = 14'd1 << 13;
  localparam logic [13:0] M_CV    = 14'd1 << 12;
  localparam logic [13:0] M_DSEL  = 14'd1 << 11;
  localparam logic [13:0] M_REG   = 14'd1 << 10;
  localparam logic [13:0] M_KEY   = 14'd1 << 9;
  localparam logic [13:0] M_KEND  = 14'd1 << 8;
  localparam logic [13:0] M_LSB   = 14'd1 << 7;
  localparam logic [13:0] M_XDATA = 14'd1 << 6;
  localparam logic [13:0] M_CIPH  = 14'd1 << 5;
  localparam logic [13:0] M_TAG   = 14'd1 << 4;
  localparam logic [13:0] M_IA    = 14'd1 << 3;
  localparam logic [13:0] M_IB    = 14'd1 << 2;
  localparam logic [13:0] M_CLK   = 14'd1 << 1;
  localparam logic [13:0] M_BLK   = 14'd1;

  logic [13:0] obs;
  assign obs = {end_s, cv, dsel, ereg, xkey, xkend, xlsb, xdata, ciph, tag, ia, ib, clk_en, blk_en};

  logic [13:0] exp_q [$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %h expected %h", name, got, want);
  endtask

  // Compare n consecutive cycles, sampled on the falling edge.
  task automatic check_cycles(input string phase, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        $error("FAIL %s[%0d]: observed %h expected <scoreboard empty>", phase, i, obs);
      end else begin
        check($sformatf("%s[%0d]", phase, i), obs, exp_q.pop_front());
      end
    end
  endtask

  task automatic push_const(input logic [13:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_init();
    logic [13:0] v;
    exp_q.push_back(M_IA | M_CLK);
    exp_q.push_back(M_REG | M_CLK);
    for (int c = 1; c <= 11; c++) begin
      v = M_DSEL | M_REG | M_CLK;
      if (c == 11) v |= M_KEND | M_IB | M_BLK;
      exp_q.push_back(v);
    end
  endtask

  task automatic push_pb(input bit is_ad);
    logic [13:0] v;
    v = M_DSEL | M_XDATA | M_REG | M_CLK;
    if (!is_ad) v |= M_CIPH;
    exp_q.push_back(v);
    for (int c = 7; c <= 11; c++) begin
      v = M_DSEL | M_REG | M_CLK;
      if (!is_ad && c == 7) v |= M_CV;
      if (c == 11) v |= M_IB | M_BLK | (is_ad ? M_LSB : 14'd0);
      exp_q.push_back(v);
    end
  endtask

  task automatic push_fin();
    logic [13:0] v;
    exp_q.push_back(M_IA);
    exp_q.push_back(M_DSEL | M_XDATA | M_CIPH | M_KEY | M_REG | M_CLK);
    for (int c = 1; c <= 11; c++) begin
      v = M_DSEL | M_REG | M_CLK;
      if (c == 1)  v |= M_CV;
      if (c == 11) v |= M_KEND | M_TAG;
      exp_q.push_back(v);
    end
  endtask

  initial begin
    #1;
    check("reset_outputs", obs, 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_const(14'd0, 1);
    check_cycles("idle", 1);

    // Initialisation p^a
    start = 1'b1;
    push_init();
    check_cycles("init", 1);
    start = 1'b0;
    check_cycles("init", 12);
    push_const(14'd0, 2);
    check_cycles("wait_ad", 2);

    // Associated data block
    data_valid = 1'b1;
    push_pb(1'b1);
    check_cycles("ad", 1);
    data_valid = 1'b0;
    check_cycles("ad", 5);
    push_const(14'd0, 1);
    check_cycles("wait_pt", 1);

    // Plaintext blocks 2..4
    for (int b = 2; b <= 4; b++) begin
      data_valid = 1'b1;
      push_pb(1'b0);
      check_cycles($sformatf("pt%0d", b), 1);
      data_valid = 1'b0;
      check_cycles($sformatf("pt%0d", b), 5);
      push_const(14'd0, 1);
      check_cycles($sformatf("wait_pt%0d", b), 1);
    end

    // Final block with finalisation; start held high is ignored here
    start = 1'b1;
    data_valid = 1'b1;
    push_fin();
    check_cycles("fin", 1);
    data_valid = 1'b0;
    check_cycles("fin", 12);
    push_const(M_END, 2);
    check_cycles("done_hold", 2);
    start = 1'b0;
    push_const(14'd0, 2);
    check_cycles("back_idle", 2);

    // Asynchronous reset in the middle of INIT_RUN
    start = 1'b1;
    push_init();
    check_cycles("init2", 1);
    start = 1'b0;
    check_cycles("init2", 4);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_init", obs, 14'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_const(14'd0, 2);
    check_cycles("idle_after_reset", 2);
    start = 1'b1;
    push_init();
    check_cycles("init3", 1);
    start = 1'b0;
    check_cycles("init3", 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
